// File: rtl/ycr1_wbb_arb_pkg.sv
// ----------------------------------------------------------------------------
// ycr1_wbb_arb_pkg
// Shared types and helpers for the three-requester Wishbone burst arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, BUSY, GAP)
//   req_id_t    : requester index (0..NREQ-1)
//   rr_next     : requester index + 1, wrapping 2 -> 0
//   rr_add      : requester index + offset, modulo NREQ
// ----------------------------------------------------------------------------
package ycr1_wbb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  typedef logic [1:0] req_id_t;

  localparam int NREQ = 3;

  // Next requester in round-robin order.
  function automatic req_id_t rr_next(input req_id_t id);
    req_id_t nxt;
    case (id)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  // (base + off) mod NREQ, for offsets 0..2.
  function automatic req_id_t rr_add(input req_id_t base, input req_id_t off);
    req_id_t res;
    case (off)
      2'd0:    res = base;
      2'd1:    res = rr_next(base);
      default: res = rr_next(rr_next(base));
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ycr1_rr_arb3.sv
// ----------------------------------------------------------------------------
// ycr1_rr_arb3
// Combinational three-way round-robin pick. The search starts at rr_ptr and
// wraps 2 -> 0; the first requester found asserted wins.
//   req     in  [2:0] request vector
//   rr_ptr  in  2     requester with highest priority this decision
//   gnt_id  out 2     selected requester (0 when gnt_vld is low)
//   gnt_vld out 1     at least one request is present
// ----------------------------------------------------------------------------
module ycr1_rr_arb3
  import ycr1_wbb_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  req_id_t         rr_ptr,
  output req_id_t         gnt_id,
  output logic            gnt_vld
);

  req_id_t idx_s;

  // Walk the requesters in rotated order and keep the first hit.
  always_comb begin
    gnt_id  = 2'd0;
    gnt_vld = 1'b0;
    idx_s   = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      idx_s = rr_add(rr_ptr, req_id_t'(i));
      if (!gnt_vld && req[idx_s]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx_s;
      end else begin
        gnt_vld = gnt_vld;
      end
    end
  end

endmodule

// File: rtl/ycr1_wbb_arb.sv
// ----------------------------------------------------------------------------
// ycr1_wbb_arb
// Burst-aware round-robin arbiter sharing the Wishbone burst bridge master
// port between m0 (icache), m1 (dcache) and m2 (debug/DMA). A grant is held
// for a whole burst and is followed by at least two strobe-low cycles.
//   wbm_clk_i / wbm_rst_n        clock, async active-low reset
//   mN_*_i                       requester N cycle/strobe/write/adr/dat/sel/bl
//   mN_dat_o/ack_o/lack_o/err_o  response, routed only to the owner
//   s_*_o                        granted requester's request towards bridge
//   s_dat_i/ack_i/lack_i/err_i   bridge response
// ----------------------------------------------------------------------------
module ycr1_wbb_arb
  import ycr1_wbb_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = 4,
  parameter int BL = 10
) (
  input  logic          wbm_clk_i,
  input  logic          wbm_rst_n,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [BW-1:0] m0_sel_i,
  input  logic [BL-1:0] m0_bl_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_lack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [BW-1:0] m1_sel_i,
  input  logic [BL-1:0] m1_bl_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_lack_o,
  output logic          m1_err_o,
  input  logic          m2_cyc_i,
  input  logic          m2_stb_i,
  input  logic          m2_we_i,
  input  logic [AW-1:0] m2_adr_i,
  input  logic [DW-1:0] m2_dat_i,
  input  logic [BW-1:0] m2_sel_i,
  input  logic [BL-1:0] m2_bl_i,
  output logic [DW-1:0] m2_dat_o,
  output logic          m2_ack_o,
  output logic          m2_lack_o,
  output logic          m2_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [BW-1:0] s_sel_o,
  output logic [BL-1:0] s_bl_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_lack_i,
  input  logic          s_err_i
);

  arb_state_t    state_r;
  req_id_t       rr_ptr_r;
  req_id_t       gnt_r;
  logic [BL-1:0] gnt_bl_r;
  logic          gnt_we_r;
  logic [BL:0]   beat_cnt_r;

  logic [NREQ-1:0] req_s;
  req_id_t         pick_id_s;
  logic            pick_vld_s;
  logic [BL-1:0]   pick_bl_s;
  logic            pick_we_s;

  logic          g_cyc_s;
  logic          g_stb_s;
  logic          g_we_s;
  logic [AW-1:0] g_adr_s;
  logic [DW-1:0] g_dat_s;
  logic [BW-1:0] g_sel_s;
  logic [BL-1:0] g_bl_s;

  logic          busy_s;
  logic [BL:0]   burst_len_s;
  logic          cnt_sat_s;
  logic          wr_last_s;
  logic          rd_last_s;
  logic          wr_drop_s;
  logic          term_s;
  logic          lack_fwd_s;

  assign req_s = {m2_cyc_i & m2_stb_i, m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  ycr1_rr_arb3 u_rr (
    .req     (req_s),
    .rr_ptr  (rr_ptr_r),
    .gnt_id  (pick_id_s),
    .gnt_vld (pick_vld_s)
  );

  // Burst attributes of the requester the round-robin would grant now.
  always_comb begin
    pick_bl_s = {BL{1'b0}};
    pick_we_s = 1'b0;
    case (pick_id_s)
      2'd0:    begin pick_bl_s = m0_bl_i; pick_we_s = m0_we_i; end
      2'd1:    begin pick_bl_s = m1_bl_i; pick_we_s = m1_we_i; end
      2'd2:    begin pick_bl_s = m2_bl_i; pick_we_s = m2_we_i; end
      default: begin pick_bl_s = {BL{1'b0}}; pick_we_s = 1'b0; end
    endcase
  end

  // Request mux of the current grant owner.
  always_comb begin
    g_cyc_s = 1'b0;
    g_stb_s = 1'b0;
    g_we_s  = 1'b0;
    g_adr_s = {AW{1'b0}};
    g_dat_s = {DW{1'b0}};
    g_sel_s = {BW{1'b0}};
    g_bl_s  = {BL{1'b0}};
    case (gnt_r)
      2'd0: begin
        g_cyc_s = m0_cyc_i; g_stb_s = m0_stb_i; g_we_s = m0_we_i;
        g_adr_s = m0_adr_i; g_dat_s = m0_dat_i; g_sel_s = m0_sel_i; g_bl_s = m0_bl_i;
      end
      2'd1: begin
        g_cyc_s = m1_cyc_i; g_stb_s = m1_stb_i; g_we_s = m1_we_i;
        g_adr_s = m1_adr_i; g_dat_s = m1_dat_i; g_sel_s = m1_sel_i; g_bl_s = m1_bl_i;
      end
      2'd2: begin
        g_cyc_s = m2_cyc_i; g_stb_s = m2_stb_i; g_we_s = m2_we_i;
        g_adr_s = m2_adr_i; g_dat_s = m2_dat_i; g_sel_s = m2_sel_i; g_bl_s = m2_bl_i;
      end
      default: begin
        g_cyc_s = 1'b0;
      end
    endcase
  end

  assign busy_s  = (state_r == BUSY);
  assign s_cyc_o = busy_s & g_cyc_s;
  assign s_stb_o = busy_s & g_stb_s;
  assign s_we_o  = busy_s & g_we_s;
  assign s_adr_o = busy_s ? g_adr_s : {AW{1'b0}};
  assign s_dat_o = busy_s ? g_dat_s : {DW{1'b0}};
  assign s_sel_o = busy_s ? g_sel_s : {BW{1'b0}};
  assign s_bl_o  = busy_s ? g_bl_s  : {BL{1'b0}};

  // A zero burst length means a single beat.
  assign burst_len_s = (gnt_bl_r == {BL{1'b0}}) ? {{BL{1'b0}}, 1'b1} : {1'b0, gnt_bl_r};
  assign cnt_sat_s   = &beat_cnt_r;

  // The bridge never returns lack on writes, so the last write beat is found
  // by counting acks. A saturated counter wraps the sum to 0 and never matches.
  assign wr_last_s  = busy_s & gnt_we_r & s_ack_i &
                      ((beat_cnt_r + {{BL{1'b0}}, 1'b1}) == burst_len_s);
  assign rd_last_s  = busy_s & ~gnt_we_r & s_lack_i;
  // Writes may be abandoned by dropping cyc; reads keep the grant so the
  // bridge response FIFO drains to its owner.
  assign wr_drop_s  = busy_s & gnt_we_r & ~g_cyc_s & ~s_ack_i;
  assign term_s     = (busy_s & s_err_i) | rd_last_s | wr_last_s | wr_drop_s;
  assign lack_fwd_s = s_lack_i | wr_last_s;

  // Response demux: only the grant owner sees the bridge, and only in BUSY.
  always_comb begin
    m0_dat_o = {DW{1'b0}}; m0_ack_o = 1'b0; m0_lack_o = 1'b0; m0_err_o = 1'b0;
    m1_dat_o = {DW{1'b0}}; m1_ack_o = 1'b0; m1_lack_o = 1'b0; m1_err_o = 1'b0;
    m2_dat_o = {DW{1'b0}}; m2_ack_o = 1'b0; m2_lack_o = 1'b0; m2_err_o = 1'b0;
    if (busy_s) begin
      case (gnt_r)
        2'd0: begin
          m0_dat_o = s_dat_i; m0_ack_o = s_ack_i; m0_lack_o = lack_fwd_s; m0_err_o = s_err_i;
        end
        2'd1: begin
          m1_dat_o = s_dat_i; m1_ack_o = s_ack_i; m1_lack_o = lack_fwd_s; m1_err_o = s_err_i;
        end
        2'd2: begin
          m2_dat_o = s_dat_i; m2_ack_o = s_ack_i; m2_lack_o = lack_fwd_s; m2_err_o = s_err_i;
        end
        default: begin
          m0_ack_o = 1'b0;
        end
      endcase
    end else begin
      m0_ack_o = 1'b0;
    end
  end

  // Arbiter FSM: grant in IDLE, hold through the burst, one forced GAP cycle.
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      state_r    <= IDLE;
      rr_ptr_r   <= 2'd0;
      gnt_r      <= 2'd0;
      gnt_bl_r   <= {BL{1'b0}};
      gnt_we_r   <= 1'b0;
      beat_cnt_r <= {(BL+1){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_vld_s) begin
            state_r    <= BUSY;
            gnt_r      <= pick_id_s;
            gnt_bl_r   <= pick_bl_s;
            gnt_we_r   <= pick_we_s;
            beat_cnt_r <= {(BL+1){1'b0}};
            rr_ptr_r   <= rr_next(pick_id_s);
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (s_ack_i && !cnt_sat_s) begin
            beat_cnt_r <= beat_cnt_r + {{BL{1'b0}}, 1'b1};
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
          if (term_s) begin
            state_r <= GAP;
          end else begin
            state_r <= BUSY;
          end
        end
        GAP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ycr1_wbb_arb.sv
// ----------------------------------------------------------------------------
// tb_ycr1_wbb_arb
// Self-checking bench for ycr1_wbb_arb. The bench plays all three requesters
// and the bridge; expected grants come from a round-robin model over a
// request mask, expected responses from the burst rules (owner-only routing,
// last ack at max(bl,1), two strobe-low cycles between bursts).
// ----------------------------------------------------------------------------
module tb_ycr1_wbb_arb;
  import ycr1_wbb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int BL = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          cyc[3], stb[3], we[3];
  logic [AW-1:0] adr[3];
  logic [DW-1:0] dat[3];
  logic [BW-1:0] sel[3];
  logic [BL-1:0] bl[3];
  logic [DW-1:0] rdat[3];
  logic          ack[3], lack[3], err[3];

  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat;
  logic [BW-1:0] s_sel;
  logic [BL-1:0] s_bl;
  logic [DW-1:0] br_dat;
  logic          br_ack, br_lack, br_err;

  int n_checks = 0;
  int n_pass   = 0;
  int rr_ptr_m = 0;

  always #5 clk = ~clk;

  ycr1_wbb_arb #(.AW(AW), .DW(DW), .BW(BW), .BL(BL)) dut (
    .wbm_clk_i (clk),      .wbm_rst_n (rst_n),
    .m0_cyc_i  (cyc[0]),   .m0_stb_i  (stb[0]),   .m0_we_i   (we[0]),
    .m0_adr_i  (adr[0]),   .m0_dat_i  (dat[0]),   .m0_sel_i  (sel[0]),
    .m0_bl_i   (bl[0]),    .m0_dat_o  (rdat[0]),  .m0_ack_o  (ack[0]),
    .m0_lack_o (lack[0]),  .m0_err_o  (err[0]),
    .m1_cyc_i  (cyc[1]),   .m1_stb_i  (stb[1]),   .m1_we_i   (we[1]),
    .m1_adr_i  (adr[1]),   .m1_dat_i  (dat[1]),   .m1_sel_i  (sel[1]),
    .m1_bl_i   (bl[1]),    .m1_dat_o  (rdat[1]),  .m1_ack_o  (ack[1]),
    .m1_lack_o (lack[1]),  .m1_err_o  (err[1]),
    .m2_cyc_i  (cyc[2]),   .m2_stb_i  (stb[2]),   .m2_we_i   (we[2]),
    .m2_adr_i  (adr[2]),   .m2_dat_i  (dat[2]),   .m2_sel_i  (sel[2]),
    .m2_bl_i   (bl[2]),    .m2_dat_o  (rdat[2]),  .m2_ack_o  (ack[2]),
    .m2_lack_o (lack[2]),  .m2_err_o  (err[2]),
    .s_cyc_o   (s_cyc),    .s_stb_o   (s_stb),    .s_we_o    (s_we),
    .s_adr_o   (s_adr),    .s_dat_o   (s_dat),    .s_sel_o   (s_sel),
    .s_bl_o    (s_bl),     .s_dat_i   (br_dat),   .s_ack_i   (br_ack),
    .s_lack_i  (br_lack),  .s_err_i   (br_err)
  );

  task automatic clear_req(input int r);
    cyc[r] = 1'b0; stb[r] = 1'b0; we[r] = 1'b0;
    adr[r] = '0; dat[r] = '0; sel[r] = '0; bl[r] = '0;
  endtask

  task automatic drive_idle();
    for (int r = 0; r < 3; r++) clear_req(r);
    br_dat = '0; br_ack = 1'b0; br_lack = 1'b0; br_err = 1'b0;
  endtask

  // Requester r starts a burst; address low bits carry r so the owner is visible.
  task automatic set_req(input int r, input logic w, input logic [BL-1:0] b);
    cyc[r] = 1'b1; stb[r] = 1'b1; we[r] = w;
    adr[r] = ($urandom() & 32'hFFFF_FFFC) | 32'(r);
    dat[r] = $urandom(); sel[r] = 4'($urandom()); bl[r] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rr_ptr_m = 0;
  endtask

  // Round-robin reference: first set bit of mask starting at rr_ptr_m.
  function automatic int model_pick(input logic [2:0] mask);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (rr_ptr_m + k) % 3;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  // Bridge-side burst service for requester id; rel_mask requesters drop
  // their request together with the terminating beat.
  task automatic run_burst(input int id, input int exp_wait, input int err_beat,
                           input logic [2:0] rel_mask);
    int waited, n;
    logic [DW-1:0] d;
    logic is_err, bad, e_ack, e_lack, e_err;
    logic [DW-1:0] e_dat;
    waited = 0;
    @(negedge clk);
    while (!s_stb && waited < 20) begin
      @(posedge clk); #1; waited++;
      @(negedge clk);
    end
    n_checks++;
    if (s_stb !== 1'b1 || waited != exp_wait)
      $display("FAIL grant_latency m%0d: got stb=%0b after %0d cycles, expected stb=1 after %0d",
               id, s_stb, waited, exp_wait);
    else n_pass++;
    if (s_stb !== 1'b1) return;
    n_checks++;
    if (s_cyc !== 1'b1 || s_adr !== adr[id] || s_we !== we[id] || s_bl !== bl[id] ||
        s_sel !== sel[id] || s_dat !== dat[id])
      $display("FAIL grant_owner: got adr=%h we=%0b bl=%0d, expected m%0d adr=%h we=%0b bl=%0d",
               s_adr, s_we, s_bl, id, adr[id], we[id], bl[id]);
    else n_pass++;
    rr_ptr_m = (id + 1) % 3;
    n = (bl[id] == '0) ? 1 : int'(bl[id]);
    for (int b = 1; b <= n; b++) begin
      @(posedge clk); #1;
      repeat ($urandom_range(0, 2)) begin
        br_ack = 1'b0; br_lack = 1'b0; br_err = 1'b0;
        @(posedge clk); #1;
      end
      d = $urandom(); br_dat = d;
      is_err = (b == err_beat);
      br_ack  = !is_err;
      br_err  = is_err;
      br_lack = !is_err && !we[id] && (b == n);
      @(negedge clk);
      bad = 1'b0;
      for (int r = 0; r < 3; r++) begin
        e_ack  = (r == id) && !is_err;
        e_lack = (r == id) && !is_err && (b == n);
        e_err  = (r == id) && is_err;
        e_dat  = (r == id) ? d : '0;
        if (ack[r] !== e_ack || lack[r] !== e_lack || err[r] !== e_err || rdat[r] !== e_dat)
          bad = 1'b1;
      end
      n_checks++;
      if (bad)
        $display("FAIL beat_route m%0d beat %0d: got ack=%b%b%b lack=%b%b%b err=%b%b%b, expected owner m%0d err=%0b last=%0b",
                 id, b, ack[2], ack[1], ack[0], lack[2], lack[1], lack[0],
                 err[2], err[1], err[0], id, is_err, (b == n));
      else n_pass++;
      if (is_err) break;
    end
    @(posedge clk); #1;
    br_ack = 1'b0; br_lack = 1'b0; br_err = 1'b0;
    for (int r = 0; r < 3; r++) if (rel_mask[r]) clear_req(r);
    @(negedge clk);
    n_checks++;
    if (s_stb !== 1'b0 || s_cyc !== 1'b0 || dut.state_r !== GAP)
      $display("FAIL gap_cycle m%0d: got stb=%0b cyc=%0b state=%0d, expected 0 0 GAP",
               id, s_stb, s_cyc, dut.state_r);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (s_stb !== 1'b0)
      $display("FAIL idle_cycle m%0d: got stb=%0b, expected 0", id, s_stb);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive_idle();
    set_req(0, 1'b0, 10'd4);
    br_ack = 1'b1; br_lack = 1'b1; br_dat = 32'hDEAD_BEEF;
    #2;
    n_checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || s_we !== 1'b0 || s_adr !== '0 || s_dat !== '0 ||
        s_sel !== '0 || s_bl !== '0 || ack[0] !== 1'b0 || lack[0] !== 1'b0 || rdat[0] !== '0)
      $display("FAIL reset_outputs: got stb=%0b adr=%h ack0=%0b, expected all 0", s_stb, s_adr, ack[0]);
    else n_pass++;
    n_checks++;
    if (dut.state_r !== IDLE || dut.rr_ptr_r !== 2'd0 || dut.gnt_r !== 2'd0 || dut.beat_cnt_r !== '0)
      $display("FAIL reset_state: got state=%0d ptr=%0d gnt=%0d cnt=%0d, expected 0 0 0 0",
               dut.state_r, dut.rr_ptr_r, dut.gnt_r, dut.beat_cnt_r);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single_read();
    int id;
    set_req(1, 1'b0, 10'd4);
    id = model_pick(3'b010);
    run_burst(id, 1, 0, 3'b010);
  endtask

  task automatic test_rr_all();
    int id;
    do_reset();
    for (int r = 0; r < 3; r++) set_req(r, 1'b0, 10'($urandom_range(1, 4)));
    for (int k = 0; k < 4; k++) begin
      id = model_pick(3'b111);
      run_burst(id, (k == 0) ? 1 : 0, 0, (k == 3) ? 3'b111 : 3'b000);
    end
  endtask

  task automatic test_write_burst();
    int id;
    set_req(2, 1'b1, 10'd3);
    id = model_pick(3'b100);
    run_burst(id, 1, 0, 3'b100);
  endtask

  task automatic test_bl0();
    int id;
    set_req(0, 1'b0, 10'd0);
    id = model_pick(3'b001);
    run_burst(id, 1, 0, 3'b001);
    set_req(1, 1'b1, 10'd0);
    id = model_pick(3'b010);
    run_burst(id, 1, 0, 3'b010);
    n_checks++;
    if (dut.beat_cnt_r !== 11'd1)
      $display("FAIL bl0_counter: got %0d, expected 1", dut.beat_cnt_r);
    else n_pass++;
  endtask

  task automatic test_err();
    int id;
    do_reset();
    set_req(0, 1'b0, 10'd8);
    set_req(1, 1'b0, 10'd3);
    set_req(2, 1'b1, 10'd2);
    id = model_pick(3'b111);
    run_burst(id, 1, 2, 3'b111);
  endtask

  task automatic test_write_abort();
    int id;
    logic bad;
    set_req(2, 1'b1, 10'd5);
    id = model_pick(3'b100);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (s_stb !== 1'b1 || s_adr !== adr[id])
      $display("FAIL abort_grant: got stb=%0b adr=%h, expected 1 %h", s_stb, s_adr, adr[id]);
    else n_pass++;
    rr_ptr_m = (id + 1) % 3;
    bad = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      br_ack = 1'b1; br_dat = $urandom();
      @(negedge clk);
      if (ack[2] !== 1'b1 || lack[2] !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL abort_beats: got ack=%0b lack=%0b, expected 1 0", ack[2], lack[2]);
    else n_pass++;
    @(posedge clk); #1;
    br_ack = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    @(posedge clk); #1;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_stb !== 1'b0 || dut.state_r !== GAP)
      $display("FAIL abort_release: got stb=%0b state=%0d, expected 0 GAP", s_stb, dut.state_r);
    else n_pass++;
    @(posedge clk); #1;
    clear_req(2);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int id;
    do_reset();
    set_req(1, 1'b0, 10'd6);
    id = model_pick(3'b010);
    @(posedge clk); #1;
    br_ack = 1'b1; br_dat = $urandom();
    @(posedge clk); #1;
    br_dat = $urandom();
    @(negedge clk);
    n_checks++;
    if (ack[id] !== 1'b1 || rdat[id] !== br_dat)
      $display("FAIL midburst_ack: got ack=%0b dat=%h, expected 1 %h", ack[id], rdat[id], br_dat);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || s_adr !== '0 || s_bl !== '0 ||
        ack[1] !== 1'b0 || lack[1] !== 1'b0 || rdat[1] !== '0)
      $display("FAIL midburst_reset_out: got stb=%0b ack1=%0b dat1=%h, expected all 0", s_stb, ack[1], rdat[1]);
    else n_pass++;
    n_checks++;
    if (dut.state_r !== IDLE || dut.rr_ptr_r !== 2'd0 || dut.beat_cnt_r !== '0)
      $display("FAIL midburst_reset_state: got state=%0d ptr=%0d cnt=%0d, expected IDLE 0 0",
               dut.state_r, dut.rr_ptr_r, dut.beat_cnt_r);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_random();
    logic [2:0] mask;
    int id, n, eb;
    for (int it = 0; it < 14; it++) begin
      mask = 3'($urandom_range(1, 7));
      for (int r = 0; r < 3; r++)
        if (mask[r]) set_req(r, 1'($urandom()), 10'($urandom_range(0, 5)));
      id = model_pick(mask);
      n = (bl[id] == '0) ? 1 : int'(bl[id]);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      run_burst(id, 1, eb, 3'b111);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_all();
    test_write_burst();
    test_bl0();
    test_err();
    test_write_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
